// File: rtl/serial_mod_pkg.sv
// Shared types and limits for the serial mod-N divisibility checker.
package serial_mod_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    localparam int DIVISOR_MIN = 2;
    localparam int DIVISOR_MAX = 256;

endpackage

// File: rtl/mod_n_step.sv
// One MSB-first remainder step: next = (2*base + bit) mod DIVISOR.
// Since base < DIVISOR, one conditional subtract is enough.
module mod_n_step #(
    parameter  int DIVISOR = 3,
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] base_i,
    input  logic             bit_i,
    output logic [REM_W-1:0] next_o
);

    localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);

    logic [REM_W:0] t_s;

    // Shift in the new bit and fold back into range
    always_comb begin
        t_s = {base_i, bit_i};
        if (t_s >= DIV_C) begin
            next_o = REM_W'(t_s - DIV_C);
        end else begin
            next_o = t_s[REM_W-1:0];
        end
    end

endmodule

// File: rtl/serial_mod_n_checker.sv
// Streaming divisibility checker for MSB-first serial frames with a
// per-beat divisible flag and a registered valid/ready frame result.
module serial_mod_n_checker
    import serial_mod_pkg::*;
#(
    parameter  int DIVISOR  = 3,
    parameter  int MAX_BITS = 64,
    localparam int REM_W    = $clog2(DIVISOR),
    localparam int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_bit_i,
    input  logic             in_sof_i,
    input  logic             in_eof_i,
    output logic             div_o,
    output logic [REM_W-1:0] rem_o,
    output logic             abort_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_div_o,
    output logic [REM_W-1:0] res_rem_o,
    output logic [LEN_W-1:0] res_len_o,
    output logic             res_ovf_o
);

    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX || MAX_BITS < 1) begin : g_param_check
        $fatal(1, "serial_mod_n_checker: DIVISOR must be 2..256 and MAX_BITS >= 1");
    end

    typedef struct packed {
        logic             div;
        logic [REM_W-1:0] rem;
        logic [LEN_W-1:0] len;
        logic             ovf;
    } mod_result_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    frame_state_t     state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             abort_q, abort_d;
    mod_result_t      res_q, res_d;
    logic             res_valid_q, res_valid_d;

    logic             accept_s;
    logic             base_reset_s;
    logic [REM_W-1:0] base_s;
    logic [REM_W-1:0] next_rem_s;
    logic [LEN_W-1:0] len_step_s;
    logic             ovf_step_s;

    assign in_ready_o = !res_valid_q | res_ready_i;
    assign accept_s   = in_valid_i & in_ready_o;

    mod_n_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .base_i (base_s),
        .bit_i  (in_bit_i),
        .next_o (next_rem_s)
    );

    // Beat arithmetic: a sof or any bit arriving in IDLE starts from zero
    always_comb begin
        base_reset_s = in_sof_i | (state_q == IDLE);
        if (base_reset_s) begin
            base_s     = {REM_W{1'b0}};
            len_step_s = LEN_ONE;
            ovf_step_s = 1'b0;
        end else begin
            base_s     = rem_q;
            len_step_s = (len_q == LEN_MAX) ? LEN_MAX : len_q + LEN_ONE;
            ovf_step_s = ovf_q | (len_q == LEN_MAX);
        end
        div_o = in_valid_i & (next_rem_s == {REM_W{1'b0}});
    end

    // Frame FSM, running state and result handshake next-state
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        abort_d     = 1'b0;
        res_d       = res_q;
        res_valid_d = res_valid_q;

        if (accept_s) begin
            abort_d = in_sof_i & (state_q == ACTIVE);
            if (in_eof_i) begin
                state_d = IDLE;
                rem_d   = {REM_W{1'b0}};
                len_d   = {LEN_W{1'b0}};
                ovf_d   = 1'b0;
            end else begin
                state_d = ACTIVE;
                rem_d   = next_rem_s;
                len_d   = len_step_s;
                ovf_d   = ovf_step_s;
            end
        end else begin
            abort_d = 1'b0;
        end

        // A fresh result wins over a same-cycle consume
        if (accept_s & in_eof_i) begin
            res_d.div   = (next_rem_s == {REM_W{1'b0}});
            res_d.rem   = next_rem_s;
            res_d.len   = len_step_s;
            res_d.ovf   = ovf_step_s;
            res_valid_d = 1'b1;
        end else if (res_valid_q & res_ready_i) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= {REM_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            res_q       <= '{div: 1'b0, rem: {REM_W{1'b0}}, len: {LEN_W{1'b0}}, ovf: 1'b0};
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign rem_o       = rem_q;
    assign abort_o     = abort_q;
    assign res_valid_o = res_valid_q;
    assign res_div_o   = res_q.div;
    assign res_rem_o   = res_q.rem;
    assign res_len_o   = res_q.len;
    assign res_ovf_o   = res_q.ovf;

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// Directed bench: four checker instances (mod 3, mod 5, mod 3 with
// MAX_BITS=8, mod 4) share one input stream; expectations are hand-computed.
module tb_serial_mod_n_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_bit, in_sof, in_eof, res_ready;

    logic       rdy3, div3, abort3, rv3, rdiv3, rovf3;
    logic [1:0] rem3, rrem3;
    logic [6:0] rlen3;
    logic       rdy5, div5, abort5, rv5, rdiv5, rovf5;
    logic [2:0] rem5, rrem5;
    logic [6:0] rlen5;
    logic       rdy8, div8, abort8, rv8, rdiv8, rovf8;
    logic [1:0] rem8, rrem8;
    logic [3:0] rlen8;
    logic       rdy4, div4, abort4, rv4, rdiv4, rovf4;
    logic [1:0] rem4, rrem4;
    logic [6:0] rlen4;

    int n_cmp = 0;
    int n_err = 0;

    serial_mod_n_checker #(.DIVISOR(3), .MAX_BITS(64)) u3 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy3),
        .in_bit_i(in_bit), .in_sof_i(in_sof), .in_eof_i(in_eof), .div_o(div3),
        .rem_o(rem3), .abort_o(abort3), .res_valid_o(rv3), .res_ready_i(res_ready),
        .res_div_o(rdiv3), .res_rem_o(rrem3), .res_len_o(rlen3), .res_ovf_o(rovf3));

    serial_mod_n_checker #(.DIVISOR(5), .MAX_BITS(64)) u5 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy5),
        .in_bit_i(in_bit), .in_sof_i(in_sof), .in_eof_i(in_eof), .div_o(div5),
        .rem_o(rem5), .abort_o(abort5), .res_valid_o(rv5), .res_ready_i(res_ready),
        .res_div_o(rdiv5), .res_rem_o(rrem5), .res_len_o(rlen5), .res_ovf_o(rovf5));

    serial_mod_n_checker #(.DIVISOR(3), .MAX_BITS(8)) u8 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy8),
        .in_bit_i(in_bit), .in_sof_i(in_sof), .in_eof_i(in_eof), .div_o(div8),
        .rem_o(rem8), .abort_o(abort8), .res_valid_o(rv8), .res_ready_i(res_ready),
        .res_div_o(rdiv8), .res_rem_o(rrem8), .res_len_o(rlen8), .res_ovf_o(rovf8));

    serial_mod_n_checker #(.DIVISOR(4), .MAX_BITS(64)) u4 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .in_bit_i(in_bit), .in_sof_i(in_sof), .in_eof_i(in_eof), .div_o(div4),
        .rem_o(rem4), .abort_o(abort4), .res_valid_o(rv4), .res_ready_i(res_ready),
        .res_div_o(rdiv4), .res_rem_o(rrem4), .res_len_o(rlen4), .res_ovf_o(rovf4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic s, input logic e);
        in_valid = v;
        in_bit   = b;
        in_sof   = s;
        in_eof   = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; res_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_rem", 32'(rem3), 32'd0);
        chk("rst_res_valid", 32'(rv3), 32'd0);
        chk("rst_res_rem", 32'(rrem3), 32'd0);
        chk("rst_res_len", 32'(rlen3), 32'd0);
        chk("rst_res_div", 32'(rdiv3), 32'd0);
        chk("rst_res_ovf", 32'(rovf3), 32'd0);
        chk("rst_abort", 32'(abort3), 32'd0);
        chk("rst_in_ready", 32'(rdy3), 32'd1);
        reset = 1'b0;
        tick();

        // Frame 110 = 6
        drive(1'b1, 1'b1, 1'b1, 1'b0); chk("t1_div0", 32'(div3), 32'd0);
        tick();                        chk("t1_rem0", 32'(rem3), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0); chk("t1_div1", 32'(div3), 32'd1);
        tick();                        chk("t1_rem1", 32'(rem3), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1); chk("t1_div2", 32'(div3), 32'd1);
        tick();
        chk("t1_res_valid", 32'(rv3), 32'd1);
        chk("t1_res_rem", 32'(rrem3), 32'd0);
        chk("t1_res_div", 32'(rdiv3), 32'd1);
        chk("t1_res_len", 32'(rlen3), 32'd3);
        chk("t1_res_ovf", 32'(rovf3), 32'd0);
        chk("t1_rem_clr", 32'(rem3), 32'd0);
        chk("t1_m5_rem", 32'(rrem5), 32'd1);
        chk("t1_m4_rem", 32'(rrem4), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t1_consumed", 32'(rv3), 32'd0);

        // Frame 1011 = 11 with the consumer stalled
        res_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0); chk("t2_div0", 32'(div5), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0); chk("t2_div1", 32'(div5), 32'd0);
        tick();                        chk("t2_rem1", 32'(rem5), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0); chk("t2_div2", 32'(div5), 32'd1);
        tick();                        chk("t2_rem2", 32'(rem5), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1); chk("t2_div3", 32'(div5), 32'd0);
        tick();
        chk("t2_res_valid", 32'(rv5), 32'd1);
        chk("t2_res_rem", 32'(rrem5), 32'd1);
        chk("t2_res_div", 32'(rdiv5), 32'd0);
        chk("t2_res_len", 32'(rlen5), 32'd4);
        chk("t2_m3_rem", 32'(rrem3), 32'd2);
        chk("t2_m4_rem", 32'(rrem4), 32'd3);

        // Backpressure: 1-bit frame held, then accepted with the consume
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t3_ready_low", 32'(rdy5), 32'd0);
        chk("t3_div_stalled", 32'(div5), 32'd1);
        tick();
        chk("t3_hold_valid", 32'(rv5), 32'd1);
        chk("t3_hold_rem", 32'(rrem5), 32'd1);
        chk("t3_hold_len", 32'(rlen5), 32'd4);
        res_ready = 1'b1;
        #1;
        chk("t3_ready_high", 32'(rdy5), 32'd1);
        tick();
        chk("t3_reload_valid", 32'(rv5), 32'd1);
        chk("t3_reload_rem", 32'(rrem5), 32'd0);
        chk("t3_reload_div", 32'(rdiv5), 32'd1);
        chk("t3_reload_len", 32'(rlen5), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3_consumed", 32'(rv5), 32'd0);

        // Ten ones = 1023: saturates the MAX_BITS=8 instance
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t4_valid", 32'(rv8), 32'd1);
        chk("t4_len_sat", 32'(rlen8), 32'd8);
        chk("t4_ovf", 32'(rovf8), 32'd1);
        chk("t4_rem", 32'(rrem8), 32'd0);
        chk("t4_div", 32'(rdiv8), 32'd1);
        chk("t4_len_wide", 32'(rlen3), 32'd10);
        chk("t4_ovf_wide", 32'(rovf3), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Abort: 1,0 then a new sof+eof with bit 1
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t5_rem_partial", 32'(rem3), 32'd2);
        chk("t5_no_result", 32'(rv3), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t5_abort", 32'(abort3), 32'd1);
        chk("t5_valid", 32'(rv3), 32'd1);
        chk("t5_rem", 32'(rrem3), 32'd1);
        chk("t5_len", 32'(rlen3), 32'd1);
        chk("t5_div", 32'(rdiv3), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t5_abort_pulse", 32'(abort3), 32'd0);
        chk("t5_consumed", 32'(rv3), 32'd0);

        // Asynchronous reset with a result pending
        res_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t6_pending", 32'(rv3), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(rv3), 32'd0);
        chk("t6_rst_res_rem", 32'(rrem3), 32'd0);
        tick();
        reset = 1'b0; res_ready = 1'b1;
        tick();

        // Asynchronous reset mid-frame after 1,1
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t6_mid_rem", 32'(rem5), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_rem", 32'(rem5), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t6_res_valid", 32'(rv3), 32'd1);
        chk("t6_res_rem", 32'(rrem3), 32'd0);
        chk("t6_res_div", 32'(rdiv3), 32'd1);
        chk("t6_res_len", 32'(rlen3), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Implicit frame start: bits in IDLE without sof, 10 = 2
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t7_res_rem", 32'(rrem3), 32'd2);
        chk("t7_res_len", 32'(rlen3), 32'd2);
        chk("t7_m4_rem", 32'(rrem4), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
